mbox_mem_responder: RTL and testbench
=====================================

// Module: mbox_mem_responder
// PURPOSE
//  Memory-side end of the MBOX quadword transfer protocol: the source of MEM_DATA_IN words the MB captures and the sink for MB write data.
//  Accepts one read or write request per transfer, acknowledges it, then moves the masked words of one quadword.
//  Words move in wrap order from the start word, one word per transfer cycle.
//  Used as the memory model behind MBOX in bench and FPGA builds.
// PARAMETERS
//  MEM_WORDS  262144  implemented words; addresses >= MEM_WORDS are non-existent (NXM)
//  ACK_DLY    2       cycles from request capture to ACKN pulse (>=1)
//  RD_DLY     1       cycles from ACKN to first read word (>=1)
// PORTS
//  clk           in   1   single clock; all state changes on posedge
//  reset_n       in   1   asynchronous, active-low reset
//  REQ           in   1   request; level, held by requester until ACKN or ERR
//  RD_RQ         in   1   read request qualifier
//  WR_RQ         in   1   write request qualifier
//  REQ_ADR       in   22  word address; [1:0] = start word within quadword
//  RQ            in   4   word mask; RQ[i] = transfer word i of the quadword
//  WR_DATA       in   36  write word from MB
//  WR_PAR        in   1   odd parity for WR_DATA
//  WR_STROBE     in   1   WR_DATA valid this cycle
//  BUSY          out  1   transfer in progress (state != IDLE)
//  ACKN          out  1   one-cycle request acknowledge
//  DATA_VALID    out  1   RD_DATA valid this cycle
//  RD_DATA       out  36  read word to MEM_DATA_IN
//  RD_PAR        out  1   odd parity for RD_DATA
//  WORD_NUM      out  2   quadword index of the word on RD_DATA or being written
//  DONE          out  1   one-cycle end-of-transfer pulse
//  ERR           out  1   one-cycle pulse: NXM, RD_RQ and WR_RQ both set, or parity error
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE. Storage is not cleared. Reset mid-transfer abandons it; words already written stay written.
//  States: IDLE -> ACKW -> (RDLY -> RXFER | WXFER) -> DONE -> IDLE.
//  IDLE: REQ=1 and exactly one of RD_RQ/WR_RQ set -> capture REQ_ADR/RQ/direction, go to ACKW.
//    REQ=1 with both qualifiers set -> ERR pulse next cycle, stay IDLE.
//    REQ=1 with neither qualifier set -> ignored.
//  ACKW: count ACK_DLY cycles. ACKN pulses in the last cycle.
//    If the captured quadword address >= MEM_WORDS: ERR and DONE pulse in the ACKN cycle, then IDLE. No data moves.
//  Word order: start = ADR[1:0], then +1 mod 4, for 4 slots. Slots with RQ clear take no cycle.
//  RXFER: after RD_DLY cycles, one masked word per cycle.
//    DATA_VALID=1; RD_DATA = mem[{ADR[21:2],WORD_NUM}]; RD_PAR = ~^RD_DATA.
//  WXFER: waits for WR_STROBE. Each strobe writes WR_DATA to the next masked word and advances.
//    Strobes in other states are ignored.
//  DONE: DONE pulses the cycle after the last word, or after ACKN when RQ=0. Then IDLE.
//  REQ held through DONE starts a new transfer only after one IDLE cycle.
//  RD_DATA/WORD_NUM hold their last value when DATA_VALID=0.
// CONFIGURATION
//  MBOX_MEM_PAR_CHECK_EN defined: a write whose WR_PAR != ~^WR_DATA still writes the data.
//    ERR pulses one cycle later. The transfer continues.
//  MBOX_MEM_PAR_CHECK_EN undefined: WR_PAR is ignored; no parity ERR source.
// STRUCTURE
//  Shared package mbox_mem_pkg: state enum t_mem_resp_state, typedef t_word (36 b), typedef t_qw_adr (20 b), function odd_par().
//  Sub-module mbox_mem_array: synchronous-write, combinational-read MEM_WORDS x 36 storage.
//  The responder holds the FSM, the delay counter and the wrap-order word sequencer.
// TESTING
//  1. Write ADR=0x100, RQ=4'b1111, 4 strobes 1,2,3,4; then read same
//     -> ACKN at cycle 2; words 0..3 = 1,2,3,4; DONE after the 4th.
//  2. Read ADR=0x102, RQ=4'b1111
//     -> WORD_NUM sequence 2,3,0,1; 4 consecutive DATA_VALID cycles; RD_PAR correct for each.
//  3. Read ADR=0x101, RQ=4'b0101
//     -> WORD_NUM 2 then 0 on consecutive cycles; DONE next cycle.
//     Read with RQ=0 -> ACKN then DONE, no DATA_VALID.
//  4. Read ADR=MEM_WORDS -> ACKN+ERR+DONE same cycle, no data.
//     RD_RQ=WR_RQ=1 -> ERR only, BUSY stays 0.
//  5. Drop reset_n during the 2nd read word -> outputs 0 immediately, state IDLE.
//     Rerun the read -> data intact.
//  6. With MBOX_MEM_PAR_CHECK_EN: write word with WR_PAR wrong -> ERR one cycle later, word still stored.
//     Without the macro -> no ERR.

Source files
------------

// File: rtl/mbox_mem_pkg.sv
// Shared types and helpers for the MBOX memory-side responder.
//   t_mem_resp_state : responder FSM states
//   t_word           : one 36-bit memory word
//   t_qw_adr         : quadword address (word address bits [21:2])
//   odd_par()        : odd parity bit for a word
//   next_word()      : wrap-order search for the next requested word
package mbox_mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACKW  = 3'd1,
    ST_RDLY  = 3'd2,
    ST_RXFER = 3'd3,
    ST_WXFER = 3'd4,
    ST_DONE  = 3'd5
  } t_mem_resp_state;

  typedef logic [35:0] t_word;
  typedef logic [19:0] t_qw_adr;

  // Odd parity: the returned bit makes the total count of ones odd.
  function automatic logic odd_par(input t_word w);
    return ~^w;
  endfunction

  // First word with its mask bit set, searching from 'from' upward mod 4.
  // Iterating from the farthest slot down lets the nearest slot win.
  function automatic logic [1:0] next_word(input logic [3:0] mask, input logic [1:0] from);
    logic [1:0] idx;
    logic [1:0] res;
    res = from;
    for (int i = 3; i >= 0; i--) begin
      idx = from + 2'(i);
      if (mask[idx]) begin
        res = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/mbox_mem_responder_if.sv
// MBOX memory transfer bus.
//   master : requester side (drives REQ/qualifiers/address/mask/write data)
//   slave  : memory responder side (drives status, read data, pulses)
interface mbox_mem_responder_if;
  import mbox_mem_pkg::*;

  logic        REQ;
  logic        RD_RQ;
  logic        WR_RQ;
  logic [21:0] REQ_ADR;
  logic [3:0]  RQ;
  t_word       WR_DATA;
  logic        WR_PAR;
  logic        WR_STROBE;
  logic        BUSY;
  logic        ACKN;
  logic        DATA_VALID;
  t_word       RD_DATA;
  logic        RD_PAR;
  logic [1:0]  WORD_NUM;
  logic        DONE;
  logic        ERR;

  modport master (
    output REQ, RD_RQ, WR_RQ, REQ_ADR, RQ, WR_DATA, WR_PAR, WR_STROBE,
    input  BUSY, ACKN, DATA_VALID, RD_DATA, RD_PAR, WORD_NUM, DONE, ERR
  );

  modport slave (
    input  REQ, RD_RQ, WR_RQ, REQ_ADR, RQ, WR_DATA, WR_PAR, WR_STROBE,
    output BUSY, ACKN, DATA_VALID, RD_DATA, RD_PAR, WORD_NUM, DONE, ERR
  );

endinterface

// File: rtl/mbox_mem_array.sv
// MEM_WORDS x 36 storage: synchronous write, combinational read. No reset,
// so contents survive a responder reset.
//   clk   : write clock
//   we    : write enable, wadr/wdata : write port
//   radr  : read address, rdata : read data (combinational)
module mbox_mem_array
  import mbox_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 262144,
  parameter int unsigned ADR_W     = 18
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADR_W-1:0] wadr,
  input  t_word            wdata,
  input  logic [ADR_W-1:0] radr,
  output t_word            rdata
);

  t_word mem [MEM_WORDS];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wadr] <= wdata;
    end
  end

  assign rdata = mem[radr];

endmodule

// File: rtl/mbox_mem_responder.sv
// Memory-side responder of the MBOX quadword transfer protocol.
// Accepts one read or write request, acknowledges it after ACK_DLY cycles,
// then moves the masked words of the quadword in wrap order from the start
// word, one word per cycle (reads) or per WR_STROBE (writes).
// Ports: clk, reset_n (async active-low), bus (mbox_mem_responder_if.slave).
// Parameters: MEM_WORDS (implemented words, higher addresses are NXM),
//   ACK_DLY (capture to ACKN, >=1), RD_DLY (ACKN to first read word, >=1).
// Build option: MBOX_MEM_PAR_CHECK_EN enables the write parity ERR source.
module mbox_mem_responder
  import mbox_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 262144,
  parameter int unsigned ACK_DLY   = 2,
  parameter int unsigned RD_DLY    = 1
) (
  input logic                 clk,
  input logic                 reset_n,
  mbox_mem_responder_if.slave bus
);

  localparam int unsigned ADR_W = $clog2(MEM_WORDS);

  t_mem_resp_state state_r, state_s;
  logic [7:0]      cnt_r, cnt_s;
  t_qw_adr         qw_r, qw_s;
  logic [1:0]      start_r, start_s;
  logic [3:0]      rem_r, rem_s;
  logic            dir_r, dir_s;         // 1 = read
  logic [1:0]      word_num_r, word_s;
  logic            busy_r, ackn_r, dv_r, rd_par_r, done_r, err_r;
  t_word           rd_data_r, rd_data_s;
  logic            ackn_s, dv_s, rd_par_s, done_s, err_s, mem_we_s;
  t_word           mem_rdata_s;
  logic [ADR_W-1:0] rd_adr_s, wr_adr_s;
  logic [21-ADR_W:0] unused_rd_hi_s, unused_wr_hi_s;

  // Quadword lies (partly) beyond the implemented words.
  function automatic logic is_nxm(input t_qw_adr qw);
    return {10'd0, qw, 2'b00} >= MEM_WORDS;
  endfunction

  // Read port follows the word about to be presented; write port the current word.
  assign {unused_rd_hi_s, rd_adr_s} = {qw_s, word_s};
  assign {unused_wr_hi_s, wr_adr_s} = {qw_r, word_num_r};

  mbox_mem_array #(
    .MEM_WORDS(MEM_WORDS),
    .ADR_W    (ADR_W)
  ) u_array (
    .clk  (clk),
    .we   (mem_we_s),
    .wadr (wr_adr_s),
    .wdata(bus.WR_DATA),
    .radr (rd_adr_s),
    .rdata(mem_rdata_s)
  );

`ifndef MBOX_MEM_PAR_CHECK_EN
  logic unused_par_s;
  assign unused_par_s = bus.WR_PAR;
`endif

  // Next-state, sequencer and next-output logic; outputs are registered below.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    qw_s     = qw_r;
    start_s  = start_r;
    rem_s    = rem_r;
    dir_s    = dir_r;
    word_s   = word_num_r;
    ackn_s   = 1'b0;
    dv_s     = 1'b0;
    done_s   = 1'b0;
    err_s    = 1'b0;
    mem_we_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.REQ && bus.RD_RQ && bus.WR_RQ) begin
          err_s = 1'b1;
        end else if (bus.REQ && (bus.RD_RQ || bus.WR_RQ)) begin
          qw_s    = bus.REQ_ADR[21:2];
          start_s = bus.REQ_ADR[1:0];
          rem_s   = bus.RQ;
          dir_s   = bus.RD_RQ;
          cnt_s   = 8'(ACK_DLY - 1);
          state_s = ST_ACKW;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACKW: begin
        if (cnt_r != 8'd0) begin
          cnt_s = cnt_r - 8'd1;
        end else if (is_nxm(qw_r)) begin
          state_s = ST_IDLE;
        end else if (rem_r == 4'd0) begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end else if (!dir_r) begin
          state_s = ST_WXFER;
          word_s  = next_word(rem_r, start_r);
        end else if (RD_DLY > 1) begin
          state_s = ST_RDLY;
          cnt_s   = 8'(RD_DLY - 2);
        end else begin
          state_s = ST_RXFER;
          dv_s    = 1'b1;
          word_s  = next_word(rem_r, start_r);
        end
      end
      ST_RDLY: begin
        if (cnt_r != 8'd0) begin
          cnt_s = cnt_r - 8'd1;
        end else begin
          state_s = ST_RXFER;
          dv_s    = 1'b1;
          word_s  = next_word(rem_r, start_r);
        end
      end
      ST_RXFER: begin
        rem_s = rem_r & ~(4'b0001 << word_num_r);
        if (rem_s != 4'd0) begin
          dv_s   = 1'b1;
          word_s = next_word(rem_s, word_num_r + 2'd1);
        end else begin
          state_s = ST_DONE;
          done_s  = 1'b1;
        end
      end
      ST_WXFER: begin
        if (bus.WR_STROBE) begin
          mem_we_s = 1'b1;
          rem_s    = rem_r & ~(4'b0001 << word_num_r);
`ifdef MBOX_MEM_PAR_CHECK_EN
          err_s    = (bus.WR_PAR != odd_par(bus.WR_DATA));
`endif
          if (rem_s != 4'd0) begin
            word_s = next_word(rem_s, word_num_r + 2'd1);
          end else begin
            state_s = ST_DONE;
            done_s  = 1'b1;
          end
        end else begin
          state_s = ST_WXFER;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    // Last ACKW cycle carries ACKN; an NXM request also ends right there.
    if ((state_s == ST_ACKW) && (cnt_s == 8'd0)) begin
      ackn_s = 1'b1;
      if (is_nxm(qw_s)) begin
        err_s  = 1'b1;
        done_s = 1'b1;
      end else begin
        err_s  = err_s;
      end
    end else begin
      ackn_s = 1'b0;
    end
  end

  // Read data and parity update only with a valid word; otherwise hold.
  always_comb begin
    if (dv_s) begin
      rd_data_s = mem_rdata_s;
      rd_par_s  = odd_par(mem_rdata_s);
    end else begin
      rd_data_s = rd_data_r;
      rd_par_s  = rd_par_r;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 8'd0;
      qw_r       <= 20'd0;
      start_r    <= 2'd0;
      rem_r      <= 4'd0;
      dir_r      <= 1'b0;
      word_num_r <= 2'd0;
      busy_r     <= 1'b0;
      ackn_r     <= 1'b0;
      dv_r       <= 1'b0;
      rd_data_r  <= 36'd0;
      rd_par_r   <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      qw_r       <= qw_s;
      start_r    <= start_s;
      rem_r      <= rem_s;
      dir_r      <= dir_s;
      word_num_r <= word_s;
      busy_r     <= (state_s != ST_IDLE);
      ackn_r     <= ackn_s;
      dv_r       <= dv_s;
      rd_data_r  <= rd_data_s;
      rd_par_r   <= rd_par_s;
      done_r     <= done_s;
      err_r      <= err_s;
    end
  end

  assign bus.BUSY       = busy_r;
  assign bus.ACKN       = ackn_r;
  assign bus.DATA_VALID = dv_r;
  assign bus.RD_DATA    = rd_data_r;
  assign bus.RD_PAR     = rd_par_r;
  assign bus.WORD_NUM   = word_num_r;
  assign bus.DONE       = done_r;
  assign bus.ERR        = err_r;

endmodule

// File: tb/tb_mbox_mem_responder.sv
// Self-checking bench for mbox_mem_responder (default parameters).
// Table of transfers with hand-computed expectations plus hand-written
// sequences for reset state, reset mid-read and REQ held through DONE.
module tb_mbox_mem_responder;

  typedef struct {
    logic            rd;
    logic            wr;
    logic [21:0]     adr;
    logic [3:0]      rq;
    int              n;
    logic [3:0][1:0] order;
    int              ack;
    int              err;
    int              done;
    logic [3:0][35:0] wd;
    logic [3:0]      bad_par;
  } vec_t;

  typedef struct {
    int               ack;
    int               err;
    int               err_cnt;
    int               done;
    int               nv;
    int               busy;
    logic [3:0][1:0]  wn;
    logic [3:0][35:0] data;
    logic [3:0]       par;
    int               dvc [4];
  } obs_t;

`ifdef MBOX_MEM_PAR_CHECK_EN
  localparam int PAR_ERR_CYC = 4;
`else
  localparam int PAR_ERR_CYC = -1;
`endif

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  logic [35:0] model [logic [21:0]];
  vec_t vecs [15];

  mbox_mem_responder_if bus();

  mbox_mem_responder dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rd, input logic wr, input logic [21:0] adr,
                              input logic [3:0] rq, input int n,
                              input int o0, input int o1, input int o2, input int o3,
                              input int ack, input int err, input int done,
                              input logic [35:0] d0, input logic [35:0] d1,
                              input logic [35:0] d2, input logic [35:0] d3,
                              input logic [3:0] bp);
    vec_t v;
    v.rd = rd; v.wr = wr; v.adr = adr; v.rq = rq; v.n = n;
    v.order[0] = 2'(o0); v.order[1] = 2'(o1); v.order[2] = 2'(o2); v.order[3] = 2'(o3);
    v.ack = ack; v.err = err; v.done = done;
    v.wd[0] = d0; v.wd[1] = d1; v.wd[2] = d2; v.wd[3] = d3;
    v.bad_par = bp;
    return v;
  endfunction

  // Runs one request for a fixed 20-cycle window; cycle 1 is the cycle after capture.
  task automatic run_vec(input vec_t v, output obs_t o);
    int ns;
    int nw;
    logic strobing;
    ns = 0; nw = 0; strobing = 1'b0;
    o.ack = -1; o.err = -1; o.err_cnt = 0; o.done = -1; o.nv = 0; o.busy = 0;
    o.wn = '0; o.data = '0; o.par = '0;
    for (int k = 0; k < 4; k++) o.dvc[k] = -1;
    @(negedge clk);
    bus.REQ = 1'b1; bus.RD_RQ = v.rd; bus.WR_RQ = v.wr;
    bus.REQ_ADR = v.adr; bus.RQ = v.rq; bus.WR_STROBE = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      bus.WR_STROBE = 1'b0;
      if (bus.BUSY) o.busy++;
      if (bus.ACKN && o.ack < 0) o.ack = c;
      if (bus.ERR) begin
        o.err_cnt++;
        if (o.err < 0) o.err = c;
      end
      if (bus.DONE && o.done < 0) o.done = c;
      if (bus.ACKN || bus.ERR) bus.REQ = 1'b0;
      if (bus.DATA_VALID) begin
        if (nw < 4) begin
          o.wn[nw] = bus.WORD_NUM; o.data[nw] = bus.RD_DATA;
          o.par[nw] = bus.RD_PAR; o.dvc[nw] = c;
        end
        nw++;
        o.nv++;
      end
      if (strobing && ns < $countones(v.rq)) begin
        bus.WR_STROBE = 1'b1;
        bus.WR_DATA = v.wd[ns];
        bus.WR_PAR = (~^v.wd[ns]) ^ v.bad_par[ns];
        o.wn[ns] = bus.WORD_NUM;
        ns++;
      end
      if (bus.ACKN && v.wr && !v.rd) strobing = 1'b1;
    end
    bus.REQ = 1'b0; bus.RD_RQ = 1'b0; bus.WR_RQ = 1'b0;
  endtask

  task automatic check_vec(input int i);
    vec_t v;
    obs_t o;
    logic [35:0] ed;
    int eb;
    v = vecs[i];
    run_vec(v, o);
    eb = (v.done > 0) ? v.done : ((v.ack > 0) ? v.ack : 0);
    chk($sformatf("v%0d ack_cyc", i), o.ack, v.ack);
    chk($sformatf("v%0d err_cyc", i), o.err, v.err);
    chk($sformatf("v%0d err_cnt", i), o.err_cnt, (v.err >= 0) ? 1 : 0);
    chk($sformatf("v%0d done_cyc", i), o.done, v.done);
    chk($sformatf("v%0d dv_cnt", i), o.nv, (v.rd && !v.wr) ? v.n : 0);
    chk($sformatf("v%0d busy_cycles", i), o.busy, eb);
    for (int k = 0; k < v.n; k++) begin
      chk($sformatf("v%0d word_num[%0d]", i, k), o.wn[k], v.order[k]);
      if (v.rd && !v.wr) begin
        ed = model.exists({v.adr[21:2], v.order[k]}) ? model[{v.adr[21:2], v.order[k]}] : 36'hx;
        chk($sformatf("v%0d rd_data[%0d]", i, k), o.data[k], ed);
        chk($sformatf("v%0d rd_par[%0d]", i, k), o.par[k], ~^ed);
        chk($sformatf("v%0d dv_cyc[%0d]", i, k), o.dvc[k], v.ack + 1 + k);
      end
    end
    if (v.wr && !v.rd) begin
      for (int k = 0; k < v.n; k++) model[{v.adr[21:2], v.order[k]}] = v.wd[k];
    end
  endtask

  initial begin
    int nv;
    int ack1;
    int ack2;
    logic busy5;
    checks = 0; errors = 0;
    clk = 1'b0; reset_n = 1'b0;
    bus.REQ = 1'b0; bus.RD_RQ = 1'b0; bus.WR_RQ = 1'b0; bus.REQ_ADR = 22'd0;
    bus.RQ = 4'd0; bus.WR_DATA = 36'd0; bus.WR_PAR = 1'b0; bus.WR_STROBE = 1'b0;

    //            rd    wr    adr        rq       n  order       ack err          done  data                                         badpar
    vecs[0]  = mk(1'b0, 1'b1, 22'h100,   4'b1111, 4, 0, 1, 2, 3, 2, -1,          7, 36'd1, 36'd2, 36'd3, 36'd4,                    4'b0000);
    vecs[1]  = mk(1'b1, 1'b0, 22'h100,   4'b1111, 4, 0, 1, 2, 3, 2, -1,          7, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[2]  = mk(1'b1, 1'b0, 22'h102,   4'b1111, 4, 2, 3, 0, 1, 2, -1,          7, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[3]  = mk(1'b1, 1'b0, 22'h101,   4'b0101, 2, 2, 0, 0, 0, 2, -1,          5, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[4]  = mk(1'b1, 1'b0, 22'h100,   4'b0000, 0, 0, 0, 0, 0, 2, -1,          3, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[5]  = mk(1'b1, 1'b0, 22'h40000, 4'b1111, 0, 0, 0, 0, 0, 2, 2,           2, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[6]  = mk(1'b1, 1'b1, 22'h100,   4'b1111, 0, 0, 0, 0, 0, -1, 1,         -1, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[7]  = mk(1'b0, 1'b1, 22'h203,   4'b1010, 2, 3, 1, 0, 0, 2, -1,          5, 36'hA5A5A5A5A, 36'h123456789, 36'd0, 36'd0,    4'b0000);
    vecs[8]  = mk(1'b1, 1'b0, 22'h201,   4'b1010, 2, 1, 3, 0, 0, 2, -1,          5, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[9]  = mk(1'b0, 1'b1, 22'h3FFFF, 4'b0001, 1, 0, 0, 0, 0, 2, -1,          4, 36'hFFFFFFFFF, 36'd0, 36'd0, 36'd0,            4'b0000);
    vecs[10] = mk(1'b1, 1'b0, 22'h3FFFE, 4'b0001, 1, 0, 0, 0, 0, 2, -1,          4, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[11] = mk(1'b0, 1'b1, 22'h300,   4'b0011, 2, 0, 1, 0, 0, 2, PAR_ERR_CYC, 5, 36'h0F0F0F0F0, 36'h000000001, 36'd0, 36'd0, 4'b0001);
    vecs[12] = mk(1'b1, 1'b0, 22'h300,   4'b0011, 2, 0, 1, 0, 0, 2, -1,          5, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[13] = mk(1'b0, 1'b1, 22'h300,   4'b0000, 0, 0, 0, 0, 0, 2, -1,          3, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);
    vecs[14] = mk(1'b0, 1'b0, 22'h100,   4'b1111, 0, 0, 0, 0, 0, -1, -1,        -1, 36'd0, 36'd0, 36'd0, 36'd0,                    4'b0000);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", {bus.BUSY, bus.ACKN, bus.DATA_VALID, bus.RD_DATA, bus.RD_PAR,
                          bus.WORD_NUM, bus.DONE, bus.ERR}, 44'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++) check_vec(i);

    // Reset dropped while the second read word is on the bus
    @(negedge clk);
    bus.REQ = 1'b1; bus.RD_RQ = 1'b1; bus.WR_RQ = 1'b0; bus.REQ_ADR = 22'h100; bus.RQ = 4'b1111;
    nv = 0;
    for (int c = 1; c <= 10 && nv < 2; c++) begin
      @(negedge clk);
      if (bus.ACKN) bus.REQ = 1'b0;
      if (bus.DATA_VALID) nv++;
    end
    chk("rst_mid_reached_word2", nv, 2);
    chk("rst_mid_word_num", bus.WORD_NUM, 2'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {bus.BUSY, bus.ACKN, bus.DATA_VALID, bus.RD_DATA, bus.RD_PAR,
                            bus.WORD_NUM, bus.DONE, bus.ERR}, 44'd0);
    bus.REQ = 1'b0; bus.RD_RQ = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_held_busy", bus.BUSY, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);
    check_vec(1);

    // REQ held through DONE: second capture only after one IDLE cycle
    @(negedge clk);
    bus.REQ = 1'b1; bus.RD_RQ = 1'b1; bus.REQ_ADR = 22'h203; bus.RQ = 4'b1000;
    ack1 = -1; ack2 = -1; busy5 = 1'bx;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 5) busy5 = bus.BUSY;
      if (bus.ACKN && ack1 < 0) ack1 = c;
      else if (bus.ACKN && ack2 < 0) begin
        ack2 = c;
        bus.REQ = 1'b0;
      end
    end
    bus.REQ = 1'b0; bus.RD_RQ = 1'b0;
    chk("held_req_ack1", ack1, 2);
    chk("held_req_idle_gap", busy5, 1'b0);
    chk("held_req_ack2", ack2, 7);
    repeat (4) @(negedge clk);
    chk("held_req_end_idle", bus.BUSY, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
